// File: rtl/unsigned_booth_algorithm.sv
// Sequential unsigned shift-add multiplier: one partial-product step per cycle,
// result registered on DONE and held until the operands change.
module unsigned_booth_algorithm #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone, StHold} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] qr_q;
  logic [WIDTH-1:0] mr_q;
  logic [WIDTH-1:0] q_lat_q;
  logic [CntW-1:0]  cnt_q;

  // {C,A}: the carry C lives only in sum[WIDTH] and is shifted straight into A's MSB.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, a_q};
    if (qr_q[0]) begin
      sum = {1'b0, a_q} + {1'b0, mr_q};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      qr_q    <= '0;
      mr_q    <= '0;
      q_lat_q <= '0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mr_q    <= M;
          qr_q    <= Q;
          q_lat_q <= Q;
          a_q     <= '0;
          cnt_q   <= CntInit;
          state_q <= StCalc;
        end
        StCalc: begin
          // Add-then-shift of {C,A,Qr} in a single cycle.
          a_q   <= sum[WIDTH:1];
          qr_q  <= {sum[0], qr_q[WIDTH-1:1]};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          product <= {a_q, qr_q};
          state_q <= StHold;
        end
        StHold: begin
          if ((M != mr_q) || (Q != q_lat_q)) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_booth_algorithm.sv
// Directed vector bench for unsigned_booth_algorithm at WIDTH=4: latency, hold,
// operand-change restart, mid-computation operand isolation and async reset.
module tb_unsigned_booth_algorithm;

  localparam int unsigned W = 4;

  logic           clk;
  logic           n_rst;
  logic [W-1:0]   M;
  logic [W-1:0]   Q;
  logic [2*W-1:0] product;

  int n_vec;
  int n_err;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  unsigned_booth_algorithm #(.WIDTH(W)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .M       (M),
    .Q       (Q),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] exp);
    n_vec++;
    if (product !== exp) begin
      n_err++;
      $display("FAIL %s: product=%0d (0x%h) expected=%0d (0x%h) at %0t",
               name, product, product, exp, exp, $time);
    end
  endtask

  task automatic edge_chk(input string name, input logic [2*W-1:0] exp);
    @(posedge clk);
    #1;
    chk(name, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_rst = 1'b0;
    M     = '0;
    Q     = '0;

    vecs[0] = '{4'd12, 4'd6,  8'h48};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'h00};
    vecs[3] = '{4'd9,  4'd0,  8'h00};
    vecs[4] = '{4'd1,  4'd9,  8'h09};
    vecs[5] = '{4'd5,  4'd5,  8'h19};
    vecs[6] = '{4'd7,  4'd3,  8'h15};
    vecs[7] = '{4'd15, 4'd1,  8'h0F};
    vecs[8] = '{4'd2,  4'd8,  8'h10};
    vecs[9] = '{4'd13, 4'd11, 8'h8F};

    // Each vector: async reset, release before the next edge, product appears on edge 6.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      M     = vecs[i].m;
      Q     = vecs[i].q;
      n_rst = 1'b0;
      #1;
      chk("reset_clear", '0);
      n_rst = 1'b1;
      for (int e = 1; e <= 5; e++) edge_chk("pre_result", '0);
      edge_chk("result_edge6", vecs[i].exp);
      edge_chk("hold_edge7", vecs[i].exp);
      edge_chk("hold_edge8", vecs[i].exp);
    end

    // Operand change in HOLD: old value (143) for 5 edges after the leaving edge.
    @(negedge clk);
    M = 4'd7;
    Q = 4'd3;
    edge_chk("leave_hold", 8'h8F);
    for (int e = 1; e <= 5; e++) edge_chk("restart_old_held", 8'h8F);
    edge_chk("restart_result", 8'h15);
    edge_chk("restart_hold", 8'h15);

    // M toggled during CALC must not disturb the latched operands.
    @(negedge clk);
    M     = 4'd12;
    Q     = 4'd6;
    n_rst = 1'b0;
    #1;
    chk("reset_async_clear", '0);
    n_rst = 1'b1;
    edge_chk("toggle_e1", '0);
    edge_chk("toggle_e2", '0);
    @(negedge clk);
    M = 4'd3;
    edge_chk("toggle_e3", '0);
    edge_chk("toggle_e4", '0);
    edge_chk("toggle_e5", '0);
    edge_chk("toggle_result", 8'h48);
    edge_chk("toggle_leave_hold", 8'h48);

    // Now restarting with M=3,Q=6: IDLE at edge 8, CALC from edge 9. Reset mid-CALC.
    edge_chk("recalc_idle", 8'h48);
    edge_chk("recalc_calc", 8'h48);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midcalc_reset_async", '0);
    M = 4'd5;
    Q = 4'd5;
    #1;
    n_rst = 1'b1;
    for (int e = 1; e <= 5; e++) edge_chk("post_abort_pre", '0);
    edge_chk("post_abort_result", 8'h19);
    edge_chk("post_abort_hold", 8'h19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unsigned_booth_algorithm.md
UNSIGNED_BOOTH_ALGORITHM -- requirements
Module: unsigned_booth_algorithm

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 n_rst  input  1  reset; asynchronous, active-low.
REQ-004 M  input  WIDTH  unsigned multiplicand.
REQ-005 Q  input  WIDTH  unsigned multiplier.
REQ-006 product  output  2*WIDTH  registered unsigned product M*Q.

Function
REQ-007 The block SHALL implement sequential unsigned shift-add multiplication using:
- A (WIDTH bits), accumulator.
- C (1 bit), carry.
- Qr (WIDTH bits), multiplier shift register.
- Mr (WIDTH bits), latched multiplicand.
- Step counter.
REQ-008 States SHALL be IDLE, CALC, DONE and HOLD; no other states are reachable.
REQ-009 IDLE, one cycle:
- Load Mr<=M, Qr<=Q, A<=0, C<=0, counter<=WIDTH.
- Go to CALC.
REQ-010 CALC, one step per cycle:
- If Qr[0]=1, compute {C,A}=A+Mr (WIDTH+1-bit sum); else {C,A}=0 concatenated with A.
- Then logically shift {C,A,Qr} right by one in the same cycle; C becomes 0.
- Decrement the counter.
REQ-011 After exactly WIDTH CALC cycles, the state SHALL go to DONE.
REQ-012 DONE, one cycle:
- product<={A,Qr}.
- Go to HOLD.
REQ-013 HOLD:
- product and all registers hold.
- If M!=Mr or Q!=Qr_latched (a separate copy of Q captured in IDLE), go to IDLE; otherwise stay in HOLD.
REQ-014 Latency: product is valid after the 6th rising edge following reset release when WIDTH=4. In general this is WIDTH+2 edges: 1 IDLE, WIDTH CALC, 1 DONE.
REQ-015 Changes on M or Q during IDLE-to-DONE SHALL NOT affect the running computation; only operands latched in IDLE are used.
REQ-016 product SHALL keep its previous value until the next DONE cycle overwrites it; no intermediate values appear on product.
REQ-017 Arithmetic SHALL be exact for all operands: the maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits and there is no overflow.
REQ-018 An operand change detected in HOLD SHALL produce the new product WIDTH+2 edges after the edge that leaves HOLD.

Reset
REQ-019 n_rst=0 SHALL immediately, without waiting for a clock edge, clear:
- product to 0.
- A, C, Qr, Mr, the latched Q copy and the counter to 0.
- The state to IDLE.
REQ-020 Reset asserted mid-computation SHALL abort it; after release, computation restarts from IDLE with the current M and Q.
REQ-021 The first rising edge after n_rst deasserts SHALL be the IDLE load cycle.

Verification
REQ-022 M=4'b1100, Q=4'b0110, reset released before the first edge -> product=0 through edge 5; product=8'h48 (72) after edge 6; holds thereafter.
REQ-023 M=15, Q=15 -> product=8'hE1 (225) after edge 6.
REQ-024 M=0, Q=9 and separately M=9, Q=0 -> product=8'h00; M=1, Q=9 -> product=8'h09.
REQ-025 After a result in HOLD, change to M=7, Q=3 -> old product held for 5 edges after the edge that leaves HOLD, then product=8'h15 (21) on the 6th.
REQ-026 M=12, Q=6; toggle M to 3 during CALC -> product=8'h48 (the latched operands are used).
REQ-027 Assert n_rst during CALC -> product=0 immediately with no clock needed; after release with M=5, Q=5 -> product=8'h19 after edge 6.
